// File: rtl/wfull_sync_flag.sv
// Write-domain status stage of the async FIFO: synchronises the read Gray pointer and
// derives full, fill level and almost-full. Optional sticky overflow flag: WFULL_OVERFLOW_DET_EN.
module wfull_sync_flag #(
    parameter int D_WIDTH      = 8,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_THRESH = (1 << D_WIDTH) - 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [D_WIDTH:0] wptr,
    input  logic [D_WIDTH:0] rptr_async,
    input  logic             wr_inc,
    output logic             full,
    output logic             almost_full,
    output logic [D_WIDTH:0] wlevel
`ifdef WFULL_OVERFLOW_DET_EN
    ,
    output logic             wr_err
`endif
);

    localparam int PW = D_WIDTH + 1;
    localparam logic [PW-1:0] AFULL_T = PW'(AFULL_THRESH);

    // Prefix XOR from the MSB converts a Gray pointer to binary.
    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] sync_q [SYNC_STAGES];
    logic [PW-1:0] rptr_s;
    logic [PW-1:0] wbin_s;
    logic [PW-1:0] rbin_s;
    logic [PW-1:0] level_s;
    logic [PW-1:0] wlevel_q;
    logic [PW-1:0] wlevel_d;
    logic          almost_full_q;
    logic          almost_full_d;

    // Plain flop chain bringing the read pointer into the write clock domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= {PW{1'b0}};
            end
        end else begin
            sync_q[0] <= rptr_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign rptr_s = sync_q[SYNC_STAGES-1];

    // Full when the pointers differ only in their two MSBs (Gray form of a depth-sized gap).
    assign full = (wptr == {~rptr_s[D_WIDTH], ~rptr_s[D_WIDTH-1], rptr_s[D_WIDTH-2:0]});

    // Occupancy from binary pointers; the subtraction wraps with the pointers.
    always_comb begin
        wbin_s        = gray2bin(wptr);
        rbin_s        = gray2bin(rptr_s);
        level_s       = wbin_s - rbin_s;
        wlevel_d      = level_s;
        almost_full_d = (level_s >= AFULL_T);
    end

    // Registered level and almost-full flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wlevel_q      <= {PW{1'b0}};
            almost_full_q <= 1'b0;
        end else begin
            wlevel_q      <= wlevel_d;
            almost_full_q <= almost_full_d;
        end
    end

    assign wlevel      = wlevel_q;
    assign almost_full = almost_full_q;

`ifdef WFULL_OVERFLOW_DET_EN
    logic wr_err_q;
    logic wr_err_d;

    // Sticky: any write attempt while full latches the error until reset.
    always_comb begin
        wr_err_d = wr_err_q | (wr_inc & full);
    end

    // Overflow flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_err_d;
        end
    end

    assign wr_err = wr_err_q;
`else
    // Writes while full are already blocked by the counter, so the request is not observed.
    logic unused_wr_inc_s;
    assign unused_wr_inc_s = wr_inc;
`endif

endmodule
